// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - SPU instruction-pair fetch sequencer driving an enable-less IF/ID register
module fetch_ctrl #(
    parameter int                    PCbitsize = 11,
    parameter logic [PCbitsize-1:0]  RESET_PC  = '0,
    parameter logic [31:0]           NOP       = 32'h4020_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [PCbitsize-1:0] branch_target,
    input  logic                 stop,
    input  logic                 run,
    output logic                 imem_req,
    output logic [PCbitsize-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [31:0]          imem_data1,
    input  logic [31:0]          imem_data2,
    output logic [PCbitsize-1:0] PC_adderOut,
    output logic [31:0]          instruction1,
    output logic [31:0]          instruction2,
    output logic                 fetch_valid,
    output logic                 halted
);

    localparam logic [PCbitsize-1:0] ALIGN_MASK = ~PCbitsize'(7);
    localparam logic [PCbitsize-1:0] PC_INIT    = RESET_PC & ALIGN_MASK;
    localparam logic [PCbitsize-1:0] STEP       = PCbitsize'(8);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [PCbitsize-1:0] pc_q, pc_d;
    logic [PCbitsize-1:0] drain_addr_q, drain_addr_d;
    logic                 stop_pending_q, stop_pending_d;
    logic [31:0]          buf1_q, buf2_q;
    logic                 load_buf;
    logic [PCbitsize-1:0] target;

    assign target = branch_target & ALIGN_MASK;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            pc_q           <= PC_INIT;
            drain_addr_q   <= PC_INIT;
            stop_pending_q <= 1'b0;
            buf1_q         <= NOP;
            buf2_q         <= NOP;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            drain_addr_q   <= drain_addr_d;
            stop_pending_q <= stop_pending_d;
            if (load_buf) begin
                buf1_q <= imem_data1;
                buf2_q <= imem_data2;
            end
        end
    end

    // Redirect has priority: pc takes the target first, then stop/stall decide the state.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        drain_addr_d   = drain_addr_q;
        stop_pending_d = stop_pending_q;
        load_buf       = 1'b0;

        if (branch_taken)
            pc_d = target;
        if (stop && state_q != HALT)
            stop_pending_d = 1'b1;

        case (state_q)
            IDLE: state_d = stop ? HALT : FETCH;
            FETCH: begin
                if (imem_ack) begin
                    if (stop)
                        state_d = HALT;
                    else if (branch_taken)
                        state_d = FETCH;
                    else begin
                        load_buf = 1'b1;
                        state_d  = ISSUE;
                    end
                end else if (branch_taken || stop) begin
                    // The bus still expects the old address until the ack arrives.
                    drain_addr_d = pc_q;
                    state_d      = DRAIN;
                end
            end
            ISSUE: begin
                if (stop)
                    state_d = HALT;
                else if (branch_taken)
                    state_d = FETCH;
                else if (!stall) begin
                    pc_d    = pc_q + STEP;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (imem_ack)
                    state_d = (stop_pending_q || stop) ? HALT : FETCH;
            end
            HALT: begin
                if (run) begin
                    state_d        = FETCH;
                    stop_pending_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req     = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr    = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign PC_adderOut  = pc_q + STEP;
    assign fetch_valid  = (state_q == ISSUE);
    assign instruction1 = fetch_valid ? buf1_q : NOP;
    assign instruction2 = fetch_valid ? buf2_q : NOP;
    assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed vector bench for fetch_ctrl with an address-tagging memory model
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h4020_0000;

    logic        clk;
    logic        reset;
    logic        stall, branch_taken, stop, run;
    logic [10:0] branch_target;
    logic        imem_req;
    logic [10:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data1, imem_data2;
    logic [10:0] PC_adderOut;
    logic [31:0] instruction1, instruction2;
    logic        fetch_valid, halted;

    int errors = 0;
    int checks = 0;
    int waits  = 0;
    int cnt    = 0;

    fetch_ctrl #(.PCbitsize(11), .RESET_PC(11'h000), .NOP(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .stop(stop), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_data1(imem_data1), .imem_data2(imem_data2),
        .PC_adderOut(PC_adderOut), .instruction1(instruction1),
        .instruction2(instruction2), .fetch_valid(fetch_valid), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tag1(input logic [10:0] a);
        return {8'hA5, 13'h0, a};
    endfunction

    function automatic logic [31:0] tag2(input logic [10:0] a);
        return {8'h5A, 13'h0, a};
    endfunction

    // Memory answers after `waits` extra cycles of a held request, tagging data with the address.
    always @(negedge clk) begin
        if (!imem_req || !reset) begin
            imem_ack = 1'b0;
            cnt      = 0;
        end else if (cnt == waits) begin
            imem_ack   = 1'b1;
            cnt        = 0;
            imem_data1 = tag1(imem_addr);
            imem_data2 = tag2(imem_addr);
        end else begin
            imem_ack = 1'b0;
            cnt      = cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall, br, stop, run;
        logic [10:0] tgt;
        logic        req;
        logic [10:0] addr;
        logic        valid;
        logic [10:0] pca;
        logic [10:0] pair;
        logic        halted;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic br, input logic [10:0] tgt,
                                input logic sp, input logic rn, input logic req,
                                input logic [10:0] addr, input logic valid,
                                input logic [10:0] pca, input logic [10:0] pair,
                                input logic hl);
        vec_t v;
        v.stall = st; v.br = br; v.tgt = tgt; v.stop = sp; v.run = rn;
        v.req = req; v.addr = addr; v.valid = valid; v.pca = pca;
        v.pair = pair; v.halted = hl;
        return v;
    endfunction

    task automatic check_outputs(input string tag, input vec_t v);
        chk({tag, " req"}, {31'h0, imem_req}, {31'h0, v.req});
        if (v.req)
            chk({tag, " addr"}, {21'h0, imem_addr}, {21'h0, v.addr});
        chk({tag, " valid"}, {31'h0, fetch_valid}, {31'h0, v.valid});
        chk({tag, " pc_add"}, {21'h0, PC_adderOut}, {21'h0, v.pca});
        chk({tag, " halted"}, {31'h0, halted}, {31'h0, v.halted});
        chk({tag, " insn1"}, instruction1, v.valid ? tag1(v.pair) : NOP);
        chk({tag, " insn2"}, instruction2, v.valid ? tag2(v.pair) : NOP);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    vec_t tbl[25];
    vec_t rst_v;

    initial begin
        logic found;
        logic saw_old;
        logic saw_new;

        reset = 1'b0; stall = 0; branch_taken = 0; branch_target = '0; stop = 0; run = 0;
        imem_ack = 0; imem_data1 = '0; imem_data2 = '0;

        //            stall br tgt     stop run  req addr    vld pca     pair    hlt
        tbl[0]  = mk(0, 0, 11'h000, 0, 0,  0, 11'h000, 0, 11'h008, 11'h000, 0);
        tbl[1]  = mk(0, 0, 11'h000, 0, 0,  1, 11'h000, 0, 11'h008, 11'h000, 0);
        tbl[2]  = mk(0, 0, 11'h000, 0, 0,  0, 11'h000, 1, 11'h008, 11'h000, 0);
        tbl[3]  = mk(0, 0, 11'h000, 0, 0,  1, 11'h008, 0, 11'h010, 11'h000, 0);
        tbl[4]  = mk(0, 0, 11'h000, 0, 0,  0, 11'h000, 1, 11'h010, 11'h008, 0);
        tbl[5]  = mk(0, 0, 11'h000, 0, 0,  1, 11'h010, 0, 11'h018, 11'h000, 0);
        tbl[6]  = mk(1, 0, 11'h000, 0, 0,  0, 11'h000, 1, 11'h018, 11'h010, 0);
        tbl[7]  = mk(1, 0, 11'h000, 0, 0,  0, 11'h000, 1, 11'h018, 11'h010, 0);
        tbl[8]  = mk(1, 0, 11'h000, 0, 0,  0, 11'h000, 1, 11'h018, 11'h010, 0);
        tbl[9]  = mk(0, 0, 11'h000, 0, 0,  0, 11'h000, 1, 11'h018, 11'h010, 0);
        tbl[10] = mk(0, 0, 11'h000, 0, 0,  1, 11'h018, 0, 11'h020, 11'h000, 0);
        tbl[11] = mk(0, 0, 11'h000, 0, 0,  0, 11'h000, 1, 11'h020, 11'h018, 0);
        tbl[12] = mk(0, 1, 11'h100, 0, 0,  1, 11'h020, 0, 11'h028, 11'h000, 0);
        tbl[13] = mk(0, 0, 11'h000, 0, 0,  1, 11'h100, 0, 11'h108, 11'h000, 0);
        tbl[14] = mk(1, 1, 11'h7F8, 0, 0,  0, 11'h000, 1, 11'h108, 11'h100, 0);
        tbl[15] = mk(0, 0, 11'h000, 0, 0,  1, 11'h7F8, 0, 11'h000, 11'h000, 0);
        tbl[16] = mk(0, 0, 11'h000, 1, 0,  0, 11'h000, 1, 11'h000, 11'h7F8, 0);
        tbl[17] = mk(0, 0, 11'h000, 0, 0,  0, 11'h000, 0, 11'h000, 11'h000, 1);
        tbl[18] = mk(0, 0, 11'h000, 0, 0,  0, 11'h000, 0, 11'h000, 11'h000, 1);
        tbl[19] = mk(0, 0, 11'h000, 0, 0,  0, 11'h000, 0, 11'h000, 11'h000, 1);
        tbl[20] = mk(0, 0, 11'h000, 0, 0,  0, 11'h000, 0, 11'h000, 11'h000, 1);
        tbl[21] = mk(0, 0, 11'h000, 0, 1,  0, 11'h000, 0, 11'h000, 11'h000, 1);
        tbl[22] = mk(0, 0, 11'h000, 0, 0,  1, 11'h7F8, 0, 11'h000, 11'h000, 0);
        tbl[23] = mk(0, 0, 11'h000, 0, 0,  0, 11'h000, 1, 11'h000, 11'h7F8, 0);
        tbl[24] = mk(0, 0, 11'h000, 0, 0,  1, 11'h000, 0, 11'h008, 11'h000, 0);
        rst_v   = mk(0, 0, 11'h000, 0, 0,  0, 11'h000, 0, 11'h008, 11'h000, 0);

        repeat (2) @(posedge clk);
        step();
        check_outputs("reset_hold", rst_v);
        chk("reset_addr", {21'h0, imem_addr}, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 25; i++) begin
            check_outputs($sformatf("vec%0d", i), tbl[i]);
            stall = tbl[i].stall; branch_taken = tbl[i].br; branch_target = tbl[i].tgt;
            stop = tbl[i].stop; run = tbl[i].run;
            step();
        end
        stall = 0; branch_taken = 0; stop = 0; run = 0;

        // Branch while a slow transaction is outstanding.
        reset = 1'b0;
        step();
        waits = 3;
        reset = 1'b1;
        stop = 1;
        step();
        stop = 0;
        chk("idle_stop halted", {31'h0, halted}, 32'h1);
        chk("idle_stop req", {31'h0, imem_req}, 32'h0);
        branch_taken = 1; branch_target = 11'h023;
        step();
        branch_taken = 0;
        chk("halt_branch halted", {31'h0, halted}, 32'h1);
        chk("halt_branch pc_add", {21'h0, PC_adderOut}, 32'h028);
        run = 1;
        step();
        run = 0;
        chk("resume req", {31'h0, imem_req}, 32'h1);
        chk("resume addr", {21'h0, imem_addr}, 32'h020);
        branch_taken = 1; branch_target = 11'h40B;
        step();
        branch_taken = 0;
        chk("drain req", {31'h0, imem_req}, 32'h1);
        chk("drain addr", {21'h0, imem_addr}, 32'h020);
        chk("drain pc_add", {21'h0, PC_adderOut}, 32'h410);

        found = 0; saw_old = 0; saw_new = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (imem_req && imem_addr == 11'h408) saw_new = 1;
            if (fetch_valid) begin
                found = 1;
                if (instruction1 == tag1(11'h020)) saw_old = 1;
                chk("redir insn1", instruction1, tag1(11'h408));
                chk("redir insn2", instruction2, tag2(11'h408));
                chk("redir pc_add", {21'h0, PC_adderOut}, 32'h410);
            end else begin
                step();
            end
        end
        chk("redir found", {31'h0, found}, 32'h1);
        chk("redir fetch_addr", {31'h0, saw_new}, 32'h1);
        chk("redir old_dropped", {31'h0, saw_old}, 32'h0);

        // Asynchronous reset between clock edges while a fetch is pending.
        @(negedge clk);
        chk("pre_reset req", {31'h0, imem_req}, 32'h1);
        #3;
        reset = 1'b0;
        #1;
        check_outputs("async_reset", rst_v);
        chk("async_reset addr", {21'h0, imem_addr}, 32'h0);
        step();
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the dual-issue SPU front end. It owns the program counter and runs the request/acknowledge handshake with local-store instruction memory, one 64-bit instruction pair per transaction. It presents each pair, with its PC+8 value, to the IF/ID pipeline register. That register has no enable, so this block implements decode stall, branch redirect and stop/run by choosing what it drives into IF/ID each cycle.

## Interface
- PCbitsize, 11: PC and address width in bytes; wraps modulo 2^PCbitsize.
- RESET_PC, 0: PC after reset; bits [2:0] are forced to 0.
- NOP, 32'h4020_0000: bubble encoding driven into both instruction slots.

Ports:
- clk  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-low; asserting it forces reset state immediately.
- stall  in  1  decode cannot accept a new pair this cycle.
- branch_taken  in  1  one-cycle redirect request.
- branch_target  in  PCbitsize  redirect byte address; low 3 bits ignored.
- stop  in  1  one-cycle halt request.
- run  in  1  one-cycle resume request; only meaningful in HALT.
- imem_req  out  1  fetch request to local store.
- imem_addr  out  PCbitsize  pair address, always 8-byte aligned.
- imem_ack  in  1  one-cycle completion strobe; only valid while imem_req=1.
- imem_data1, imem_data2  in  32 each  pair returned with imem_ack.
- PC_adderOut  out  PCbitsize  address of the presented pair plus 8; drives IF/ID.
- instruction1, instruction2  out  32 each  to IF/ID.
- fetch_valid  out  1  1 when instruction1/2 carry a real pair rather than NOP.
- halted  out  1  1 in HALT.

## Operation
- Registers: pc, buffer (pair), state, stop_pending.
- States: IDLE, FETCH, ISSUE, DRAIN, HALT.
- IDLE: entered only on reset. Moves to FETCH on the next clock.
- FETCH:
  - Drives imem_req=1 and imem_addr=pc, both held stable until imem_ack.
  - On imem_ack, captures imem_data1/2 into buffer and moves to ISSUE.
- ISSUE:
  - Drives instruction1/2=buffer, PC_adderOut=pc+8 and fetch_valid=1.
  - If stall=0: pc<=pc+8, then FETCH.
  - If stall=1: stays in ISSUE, re-presenting the identical pair so IF/ID reloads the same value.
- DRAIN: a transaction is outstanding but its data must be discarded. imem_req stays 1 with the old address. On imem_ack the data is dropped and the state moves to FETCH, or to HALT if stop_pending=1.
- HALT:
  - imem_req=0 and halted=1.
  - run moves the state to FETCH at the current pc and clears stop_pending.
  - branch_taken in HALT updates pc and the state stays HALT.
- Redirect on branch_taken, which has priority over stall and stop:
  - pc<=target with bits [2:0] cleared.
  - From ISSUE: the buffered pair is discarded, then FETCH.
  - From FETCH without imem_ack in the same cycle: DRAIN.
  - From FETCH with imem_ack in the same cycle: the returned data is discarded, then FETCH.
  - From DRAIN: pc is overwritten and the state stays DRAIN.
- stop:
  - Sets stop_pending.
  - From ISSUE or IDLE, or from FETCH with imem_ack in the same cycle: HALT at the next clock, current pair discarded, pc unchanged.
  - From FETCH without imem_ack: DRAIN, which then exits to HALT.
  - If branch_taken is also asserted, pc takes the target first.
- Outside ISSUE: instruction1=instruction2=NOP, fetch_valid=0, PC_adderOut=pc+8.
- Arithmetic: pc+8 truncates to PCbitsize bits, so the maximum aligned address wraps to 0 with no flag.

## Timing
- Reset values (while reset=0 and after release):
  - state=IDLE, pc=RESET_PC, stop_pending=0.
  - imem_req=0, imem_addr=RESET_PC.
  - instruction1/2=NOP, fetch_valid=0, halted=0, PC_adderOut=RESET_PC+8.
- Reset asserted mid-transaction abandons the transaction. The memory side must tolerate imem_req dropping without imem_ack.
- Outputs are decoded from registered state only; there are no input-to-output combinational paths.
- Minimum cycles per pair, with zero-wait memory (imem_ack in the first FETCH cycle):
  - 1 cycle FETCH, then 1 cycle ISSUE.
  - One pair every 2 cycles; N wait states add N cycles.
- First real pair after reset release: IDLE(1), FETCH(1), then visible in ISSUE on cycle 3. IF/ID captures it at the end of that cycle.
- Branch redirect: the first target pair reaches ISSUE no earlier than 2 cycles after branch_taken. Add 1 cycle plus the remaining wait if it occurred during FETCH.
- imem_ack while imem_req=0 is ignored.

## Test plan
- Reset/sequential:
  - Stimulus: release reset; zero-wait memory returns pairs tagged with their address.
  - Required: imem_addr steps 0, 8, 16, 24 every 2 cycles; fetch_valid alternates 0/1; PC_adderOut = 8, 16, 24, 32 in ISSUE cycles; NOP in other cycles.
- Stall:
  - Stimulus: stall=1 for 3 cycles during ISSUE of pair @0x10.
  - Required: the identical pair with PC_adderOut=0x18 is held for 4 cycles; imem_req=0 throughout; next fetch address is 0x18.
- Branch during wait:
  - Stimulus: memory with 3 wait states; branch_taken with target 0x40B during FETCH at 0x20.
  - Required: DRAIN, old data discarded, next imem_addr=0x408; no fetch_valid for the 0x20 pair.
- Simultaneous events:
  - Stimulus 1: branch_taken together with imem_ack in FETCH. Required: data discarded, next fetch at target.
  - Stimulus 2: branch_taken together with stall=1 in ISSUE. Required: redirect wins.
- Stop/run and wrap:
  - Stimulus: stop in ISSUE at 0x7F8, then run 5 cycles later.
  - Required: halted=1 for 5 cycles with imem_req=0; fetch resumes at 0x7F8; PC_adderOut=0x000 (wrap); next fetch is 0x000.
- Async reset:
  - Stimulus: assert reset mid-FETCH, not on a clock edge.
  - Required: outputs reach reset values immediately.
